// File: rtl/reorder_buffer.sv
// In-order retirement buffer: hands out ROB ids at dispatch, accepts results by id,
// retires the oldest completed entry each cycle and flushes on an excepting head.
module reorder_buffer #(
    parameter int ADDR_WIDTH    = 4,
    parameter int RF_ADDR_WIDTH = 6,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_en,
    input  logic                     alloc_dest_en,
    input  logic [RF_ADDR_WIDTH-1:0] alloc_dest_addr,
    output logic                     alloc_ready,
    output logic [ADDR_WIDTH-1:0]    alloc_id,
    input  logic                     wb_en,
    input  logic [ADDR_WIDTH-1:0]    wb_id,
    input  logic [DATA_WIDTH-1:0]    wb_data,
    input  logic                     wb_exc,
    input  logic [ADDR_WIDTH-1:0]    read_id_1,
    input  logic [ADDR_WIDTH-1:0]    read_id_2,
    output logic                     read_ready_1,
    output logic                     read_ready_2,
    output logic [DATA_WIDTH-1:0]    read_data_1,
    output logic [DATA_WIDTH-1:0]    read_data_2,
    output logic                     commit_en,
    output logic [RF_ADDR_WIDTH-1:0] commit_addr,
    output logic [DATA_WIDTH-1:0]    commit_data,
    output logic                     commit_restore,
    output logic [ADDR_WIDTH:0]      count,
    output logic                     empty,
    output logic                     full
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [ADDR_WIDTH:0]        head, tail;
    logic [ADDR_WIDTH-1:0]      head_idx, tail_idx;
    logic [DEPTH-1:0]           ent_valid, ent_done, ent_exc, ent_dest_en;
    logic [RF_ADDR_WIDTH-1:0]   ent_dest_addr [DEPTH];
    logic [DATA_WIDTH-1:0]      ent_data [DEPTH];

    logic head_ready, restore, retire, do_alloc, do_wb;

    assign head_idx = head[ADDR_WIDTH-1:0];
    assign tail_idx = tail[ADDR_WIDTH-1:0];

    assign head_ready = ent_valid[head_idx] & ent_done[head_idx];
    assign restore    = head_ready & ent_exc[head_idx];
    assign retire     = head_ready & ~ent_exc[head_idx];

    assign full  = (head_idx == tail_idx) && (head[ADDR_WIDTH] != tail[ADDR_WIDTH]);
    assign empty = (head == tail);
    assign count = tail - head;

    // Judged on current state: a retirement this cycle cannot free a slot for this cycle.
    assign alloc_ready = !full && !restore;
    assign alloc_id    = tail_idx;
    assign do_alloc    = alloc_en && alloc_ready;
    assign do_wb       = wb_en && ent_valid[wb_id] && !restore;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head           <= '0;
            tail           <= '0;
            ent_valid      <= '0;
            ent_done       <= '0;
            ent_exc        <= '0;
            ent_dest_en    <= '0;
            commit_en      <= 1'b0;
            commit_addr    <= '0;
            commit_data    <= '0;
            commit_restore <= 1'b0;
        end else begin
            commit_restore <= restore;
            commit_en      <= retire && ent_dest_en[head_idx];
            if (retire && ent_dest_en[head_idx]) begin
                commit_addr <= ent_dest_addr[head_idx];
                commit_data <= ent_data[head_idx];
            end

            if (restore) begin
                head      <= '0;
                tail      <= '0;
                ent_valid <= '0;
            end else begin
                if (do_wb) begin
                    ent_done[wb_id] <= 1'b1;
                    ent_exc[wb_id]  <= wb_exc;
                end
                if (do_alloc) begin
                    ent_valid[tail_idx]   <= 1'b1;
                    ent_done[tail_idx]    <= 1'b0;
                    ent_exc[tail_idx]     <= 1'b0;
                    ent_dest_en[tail_idx] <= alloc_dest_en;
                    tail                  <= tail + 1'b1;
                end
                if (retire) begin
                    ent_valid[head_idx] <= 1'b0;
                    head                <= head + 1'b1;
                end
            end
        end
    end

    // Payload storage needs no reset; it is only observed through valid/done.
    always_ff @(posedge clk) begin
        if (do_alloc)
            ent_dest_addr[tail_idx] <= alloc_dest_addr;
        if (do_wb)
            ent_data[wb_id] <= wb_data;
    end

    function automatic logic [DATA_WIDTH:0] lookup(input logic [ADDR_WIDTH-1:0] id);
        logic [DATA_WIDTH:0] r;
        r = '0;
        if (wb_en && wb_id == id && ent_valid[id])
            r = {1'b1, wb_data};
        else if (ent_valid[id] && ent_done[id])
            r = {1'b1, ent_data[id]};
        return r;
    endfunction

    assign {read_ready_1, read_data_1} = lookup(read_id_1);
    assign {read_ready_2, read_data_2} = lookup(read_id_2);

endmodule
